// File: rtl/neuron_pkg.sv
// Shared constants for the LIF neuron integrator: FSM state codes, Q16.16 limits
// and the fp32 exponent break points used by the float-to-fixed converter.
package neuron_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CONV  = 2'd1;
  localparam logic [1:0] ST_INTEG = 2'd2;
  localparam logic [1:0] ST_FIRE  = 2'd3;

  localparam int Q16_FRAC_BITS  = 16;
  localparam int FP32_BIAS      = 127;
  localparam int FP32_MANT_BITS = 23;

  localparam logic signed [31:0] Q16_MAX = 32'sh7FFFFFFF;
  localparam logic signed [31:0] Q16_MIN = 32'sh80000000;

  // Exponent at which {1,mant} already sits on the Q16.16 grid (134), and the
  // first exponent whose magnitude no longer fits in 31 bits (142).
  localparam logic [7:0] EXP_UNITY = 8'(FP32_BIAS - Q16_FRAC_BITS + FP32_MANT_BITS);
  localparam logic [7:0] EXP_SAT   = 8'(FP32_BIAS + 31 - Q16_FRAC_BITS);

endpackage

// File: rtl/fp32_to_q16.sv
// Combinational IEEE-754 fp32 to signed Q16.16 converter: denormals flush to zero,
// out-of-range magnitudes (including Inf/NaN) saturate by sign, fractions truncate.
module fp32_to_q16
  import neuron_pkg::*;
(
  input  logic [31:0] fp_in,
  output logic [31:0] q_out
);

  logic        sign;
  logic [7:0]  expo;
  logic [23:0] mant;
  logic [30:0] mag;

  assign sign = fp_in[31];
  assign expo = fp_in[30:23];
  assign mant = {1'b1, fp_in[22:0]};

  always_comb begin
    mag = '0;
    if (expo >= EXP_UNITY) mag = 31'(mant) << (expo - EXP_UNITY);
    else                   mag = 31'(mant >> (EXP_UNITY - expo));

    if (expo == 8'd0)          q_out = '0;
    else if (expo >= EXP_SAT)  q_out = sign ? Q16_MIN : Q16_MAX;
    else if (sign)             q_out = 32'd0 - {1'b0, mag};
    else                       q_out = {1'b0, mag};
  end

endmodule

// File: rtl/lif_neuron_integrator.sv
// Leaky integrate-and-fire membrane: converts each MAC current to Q16.16, integrates
// with leak and saturation, and emits a valid/ready spike token on threshold crossing.
// Optional refractory period is enabled by defining NEURON_REFRACTORY_EN.
module lif_neuron_integrator
  import neuron_pkg::*;
#(
  parameter logic [11:0]        NEURON_ADDRESS = 12'd0,
  parameter logic signed [31:0] THRESHOLD      = 32'sh00640000,
  parameter logic signed [31:0] V_RESET        = 32'sh00000000,
  parameter int                 LEAK_SHIFT     = 3,
  parameter int                 REFRACT_STEPS  = 2
) (
  input  logic        CLK_Neuron,
  input  logic        RST_Neuron,
  input  logic        mac_done,
  input  logic [31:0] mult_output,
  input  logic        spike_ready,
  output logic        spike_valid,
  output logic [11:0] spike_addr,
  output logic [31:0] potential,
  output logic        busy,
  output logic        drop_err
);

  logic [1:0]          state;
  logic                pend_vld;
  logic [31:0]         pend_data;
  logic [31:0]         sample_p0;
  logic [31:0]         conv_q;
  logic signed [31:0]  cur_p1;
  logic signed [31:0]  v_q;
  logic signed [31:0]  leak;
  logic signed [33:0]  sum_w;
  logic signed [31:0]  v_next;
  logic                fire;
  logic                drop_q;

`ifdef NEURON_REFRACTORY_EN
  localparam logic [7:0] REFR_INIT = 8'(REFRACT_STEPS);
  logic [7:0] refr_cnt;
`endif

  function automatic logic signed [31:0] sat32(input logic signed [33:0] x);
    if (x > 34'sd2147483647)       return Q16_MAX;
    else if (x < -34'sd2147483648) return Q16_MIN;
    else                           return x[31:0];
  endfunction

  fp32_to_q16 u_conv (
    .fp_in (sample_p0),
    .q_out (conv_q)
  );

  // Leak of zero when LEAK_SHIFT is 0; otherwise an arithmetic shift of the potential.
  assign leak   = (LEAK_SHIFT == 0) ? 32'sd0 : (v_q >>> LEAK_SHIFT);
  assign sum_w  = {{2{v_q[31]}}, v_q} - {{2{leak[31]}}, leak} + {{2{cur_p1[31]}}, cur_p1};
  assign v_next = sat32(sum_w);
  assign fire   = (v_next >= THRESHOLD);

  assign spike_valid = (state == ST_FIRE);
  assign spike_addr  = spike_valid ? NEURON_ADDRESS : 12'd0;
  assign busy        = (state != ST_IDLE);
  assign potential   = v_q;
  assign drop_err    = drop_q;

  always_ff @(posedge CLK_Neuron) begin
    if (RST_Neuron) begin
      state    <= ST_IDLE;
      pend_vld <= 1'b0;
      drop_q   <= 1'b0;
      v_q      <= '0;
`ifdef NEURON_REFRACTORY_EN
      refr_cnt <= '0;
`endif
    end else begin
      if (mac_done && state != ST_IDLE) begin
        if (pend_vld) drop_q   <= 1'b1;
        else          pend_vld <= 1'b1;
      end
      case (state)
        // p0: latch the sample, pending entry first; a coincident mac_done refills pending
        ST_IDLE: begin
          if (pend_vld || mac_done) begin
            state <= ST_CONV;
            if (pend_vld && !mac_done) pend_vld <= 1'b0;
          end
        end
        // p1: converted current registered
        ST_CONV: state <= ST_INTEG;
        // p2: leak, integrate, threshold
        ST_INTEG: begin
          state <= ST_IDLE;
`ifdef NEURON_REFRACTORY_EN
          if (refr_cnt != 8'd0) refr_cnt <= refr_cnt - 8'd1;
          else
`endif
          if (fire) begin
            v_q   <= V_RESET;
            state <= ST_FIRE;
`ifdef NEURON_REFRACTORY_EN
            refr_cnt <= REFR_INIT;
`endif
          end else begin
            v_q <= v_next;
          end
        end
        default: if (spike_ready) state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK_Neuron) begin
    if (mac_done && ((state == ST_IDLE) ? pend_vld : !pend_vld)) pend_data <= mult_output;
    if (state == ST_IDLE) sample_p0 <= pend_vld ? pend_data : mult_output;
    if (state == ST_CONV) cur_p1 <= conv_q;
  end

endmodule

// File: tb/tb_lif_neuron_integrator.sv
// Self-checking bench for lif_neuron_integrator: directed spike/pending/saturation cases
// plus randomized samples against a transaction-level real-arithmetic neuron model.
module tb_lif_neuron_integrator;

  localparam logic [11:0] ADDR = 12'hA5C;
  localparam longint THR  = 64'sd6553600;
  localparam longint VRST = 64'sd0;
  localparam int     LEAK = 3;
`ifdef NEURON_REFRACTORY_EN
  localparam int     REFR = 2;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mac_done = 1'b0;
  logic [31:0] mult_output = '0;
  logic        spike_ready = 1'b0;
  logic        spike_valid;
  logic [11:0] spike_addr;
  logic [31:0] potential;
  logic        busy;
  logic        drop_err;

  int     n_chk = 0;
  int     n_err = 0;
  longint m_v = 0;
  bit     m_last_sp = 1'b0;
`ifdef NEURON_REFRACTORY_EN
  int     m_refr = 0;
`endif

  lif_neuron_integrator #(.NEURON_ADDRESS(ADDR)) dut (
    .CLK_Neuron  (clk),
    .RST_Neuron  (rst),
    .mac_done    (mac_done),
    .mult_output (mult_output),
    .spike_ready (spike_ready),
    .spike_valid (spike_valid),
    .spike_addr  (spike_addr),
    .potential   (potential),
    .busy        (busy),
    .drop_err    (drop_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Value of an fp32 word times 2^16, truncated toward zero, clamped to 32-bit signed.
  function automatic longint fp_ref(input logic [31:0] x);
    int     e;
    real    r;
    longint mag;
    e = int'(x[30:23]);
    if (e == 0) return 0;
    if (e >= 142) return x[31] ? -64'sd2147483648 : 64'sd2147483647;
    r   = real'(8388608 + int'(x[22:0])) * (2.0 ** (e - 134));
    mag = longint'($rtoi(r));
    return x[31] ? -mag : mag;
  endfunction

  task automatic model_step(input logic [31:0] x, output logic sp);
    longint i;
    longint lk;
    longint vn;
    sp = 1'b0;
`ifdef NEURON_REFRACTORY_EN
    if (m_refr > 0) begin
      m_refr--;
      return;
    end
`endif
    i  = fp_ref(x);
    lk = (LEAK == 0) ? 64'sd0 : (m_v >>> LEAK);
    vn = m_v - lk + i;
    if (vn > 64'sd2147483647)  vn = 64'sd2147483647;
    if (vn < -64'sd2147483648) vn = -64'sd2147483648;
    if (vn >= THR) begin
      m_v = VRST;
      sp  = 1'b1;
`ifdef NEURON_REFRACTORY_EN
      m_refr = REFR;
`endif
    end else begin
      m_v = vn;
    end
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 30) begin
      step();
      k++;
    end
    if (busy) chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic release_spike(input int d);
    repeat (d) begin
      step();
      chk("spike_hold", 32'(spike_valid), 32'd1);
      chk("addr_hold", 32'(spike_addr), 32'(ADDR));
    end
    spike_ready = 1'b1;
    step();
    spike_ready = 1'b0;
    chk("spike_clear", 32'(spike_valid), 32'd0);
  endtask

  task automatic txn(input logic [31:0] x, input bit hold);
    logic        sp;
    logic [31:0] prev;
    wait_idle();
    prev = 32'(m_v);
    model_step(x, sp);
    m_last_sp   = sp;
    mult_output = x;
    mac_done    = 1'b1;
    step();
    mac_done    = 1'b0;
    mult_output = $urandom;
    step();
    chk("pot_latency", potential, prev);
    step();
    chk("potential", potential, 32'(m_v));
    chk("spike_valid", 32'(spike_valid), 32'(sp));
    if (sp) begin
      chk("spike_addr", 32'(spike_addr), 32'(ADDR));
      if (!hold) release_spike($urandom_range(0, 3));
    end
  endtask

  initial begin
    logic        sp_a;
    logic        sp_c;
    logic [31:0] x;
    int          k;

    rst = 1'b1;
    step();
    step();
    chk("rst_spike_valid", 32'(spike_valid), 32'd0);
    chk("rst_spike_addr", 32'(spike_addr), 32'd0);
    chk("rst_potential", potential, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_drop_err", 32'(drop_err), 32'd0);
    rst = 1'b0;
    step();

    txn(32'h4290B333, 1'b0);
    chk("first_integrate", potential, 32'h00485999);
    txn(32'h4290B333, 1'b1);
    chk("fire_busy", 32'(busy), 32'd1);

    // Stalled in FIRE: first sample parks in pending, second is lost.
    mac_done    = 1'b1;
    mult_output = 32'hC2F43851;
    step();
    mult_output = 32'h3F800000;
    step();
    mac_done    = 1'b0;
    mult_output = $urandom;
    chk("drop_err_set", 32'(drop_err), 32'd1);
    chk("stall_spike_valid", 32'(spike_valid), 32'd1);
    chk("stall_potential", potential, 32'd0);
    model_step(32'hC2F43851, sp_a);
    spike_ready = 1'b1;
    step();
    spike_ready = 1'b0;
    mac_done    = 1'b1;
    mult_output = 32'h41200000;
    step();
    mac_done    = 1'b0;
    mult_output = $urandom;
    step();
    step();
    chk("drain_potential", potential, 32'(m_v));
    chk("drain_spike", 32'(spike_valid), 32'(sp_a));
    model_step(32'h41200000, sp_c);
    step();
    step();
    step();
    chk("refill_potential", potential, 32'(m_v));
    chk("refill_spike", 32'(spike_valid), 32'(sp_c));
    if (sp_c) release_spike(0);
    wait_idle();
    chk("drop_err_sticky", 32'(drop_err), 32'd1);

    txn(32'h47800000, 1'b0);
    repeat (3) txn(32'h42F43851, 1'b0);

    txn(32'h00000001, 1'b0);
    txn(32'hC7800000, 1'b0);
    txn(32'hC7800000, 1'b0);
    chk("neg_sat", potential, 32'h80000000);
    txn(32'h4290B333, 1'b0);
    txn(32'h47000000, 1'b0);

    repeat (60) begin
      x[31]    = ($urandom_range(0, 3) == 0);
      x[22:0]  = 23'($urandom);
      if ($urandom_range(0, 9) == 0)
        x[30:23] = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(142, 255));
      else
        x[30:23] = 8'($urandom_range(120, 139));
      txn(x, 1'b0);
    end

    // Reset while a token is waiting must abandon it on the same edge.
    k = 0;
    m_last_sp = 1'b0;
    while (!m_last_sp && k < 4) begin
      txn(32'h47800000, 1'b1);
      k++;
    end
    chk("pre_reset_fire", 32'(spike_valid), 32'd1);
    rst = 1'b1;
    step();
    chk("midfire_spike_valid", 32'(spike_valid), 32'd0);
    chk("midfire_spike_addr", 32'(spike_addr), 32'd0);
    chk("midfire_busy", 32'(busy), 32'd0);
    chk("midfire_drop_err", 32'(drop_err), 32'd0);
    chk("midfire_potential", potential, 32'd0);
    rst = 1'b0;
    m_v = 0;
`ifdef NEURON_REFRACTORY_EN
    m_refr = 0;
`endif
    step();
    txn(32'h4290B333, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
